// File: rtl/gps_wb_pkg.sv
// Shared types and constants for the GPS engine Wishbone channel arbiter.
package gps_wb_pkg;

  localparam int         NUM_CH_DEF    = 8;
  localparam logic [7:0] BASE_PAGE_DEF = 8'h0A;
  localparam int         PAGE_W        = 8;
  localparam int         OFS_W         = 8;
  localparam int         ERR_CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/gps_wb_rdmux.sv
// Selects one channel's read data and ack out of the concatenated channel buses.
module gps_wb_rdmux
  import gps_wb_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DW     = 32
) (
  input  logic [NUM_CH*DW-1:0] ch_dat_i,
  input  logic [NUM_CH-1:0]    ch_ack_i,
  input  logic [PAGE_W-1:0]    idx_i,
  output logic [DW-1:0]        dat_o,
  output logic                 ack_o
);

  // Pick the slice whose index matches; out-of-range indices yield zero.
  always_comb begin
    dat_o = '0;
    ack_o = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (idx_i == PAGE_W'(n)) begin
        dat_o = ch_dat_i[n*DW +: DW];
        ack_o = ch_ack_i[n];
      end
    end
  end

endmodule

// File: rtl/gps_wb_chan_arbiter.sv
// Wishbone slave front end that forwards one access at a time to a channel bank,
// with a per-access watchdog and a saturating count of error terminations.
module gps_wb_chan_arbiter
  import gps_wb_pkg::*;
#(
  parameter int         NUM_CH    = NUM_CH_DEF,
  parameter logic [7:0] BASE_PAGE = BASE_PAGE_DEF,
  parameter int         TIMEOUT   = 16,
  parameter int         DW        = 32
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [DW-1:0]        wb_dat_i,
  output logic [DW-1:0]        wb_dat_o,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 ch_cyc_o,
  output logic [NUM_CH-1:0]    ch_stb_o,
  output logic [OFS_W-1:0]     ch_adr_o,
  output logic [DW-1:0]        ch_dat_o,
  output logic                 ch_we_o,
  input  logic [NUM_CH*DW-1:0] ch_dat_i,
  input  logic [NUM_CH-1:0]    ch_ack_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [PAGE_W-1:0]      idx_q;
  logic [OFS_W-1:0]       adr_q;
  logic [DW-1:0]          dat_q;
  logic                   we_q;
  logic [7:0]             timer_q;
  logic [DW-1:0]          rdat_q;
  logic [ERR_CNT_W-1:0]   errCnt_q;

  logic [PAGE_W-1:0]      reqIdx;
  logic                   reqValid;
  logic                   reqMapped;
  logic                   accept;
  logic [DW-1:0]          selDat;
  logic                   selAck;
  logic                   unused_adr;

  // Page offset from channel 0; pages below BASE_PAGE wrap to large values and miss.
  assign reqIdx     = wb_adr_i[15:8] - BASE_PAGE;
  assign reqMapped  = reqIdx < PAGE_W'(NUM_CH);
  assign reqValid   = wb_cyc_i & wb_stb_i;
  assign accept     = (state_q == IDLE) && reqValid && reqMapped;
  assign unused_adr = ^wb_adr_i[31:16];

  gps_wb_rdmux #(
    .NUM_CH (NUM_CH),
    .DW     (DW)
  ) u_rdmux (
    .ch_dat_i (ch_dat_i),
    .ch_ack_i (ch_ack_i),
    .idx_i    (idx_q),
    .dat_o    (selDat),
    .ack_o    (selAck)
  );

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: in FWD a dropped cycle wins over an ack, which wins over the watchdog.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (reqValid) state_d = reqMapped ? FWD : ERR;
      FWD: begin
        if (!wb_cyc_i)                    state_d = IDLE;
        else if (selAck)                  state_d = RESP;
        else if (timer_q == TIMER_LAST)   state_d = ERR;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request, watchdog timer, read data capture and error counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      idx_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      timer_q  <= '0;
      rdat_q   <= '0;
      errCnt_q <= '0;
    end else begin
      if (accept) begin
        idx_q <= reqIdx;
        adr_q <= wb_adr_i[7:0];
        dat_q <= wb_dat_i;
        we_q  <= wb_we_i;
      end
      if (state_q == FWD) timer_q <= timer_q + 8'd1;
      else                timer_q <= '0;
      if ((state_q == FWD) && wb_cyc_i && selAck && !we_q) rdat_q <= selDat;
      if ((state_d == ERR) && (errCnt_q != '1)) errCnt_q <= errCnt_q + 1'b1;
    end
  end

  // Outputs decoded from the current state only.
  always_comb begin
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    ch_cyc_o = 1'b0;
    ch_stb_o = '0;
    unique case (state_q)
      FWD: begin
        ch_cyc_o = 1'b1;
        ch_stb_o = NUM_CH'(1) << idx_q;
      end
      RESP:    wb_ack_o = 1'b1;
      ERR:     wb_err_o = 1'b1;
      default: ;
    endcase
  end

  assign wb_dat_o  = rdat_q;
  assign ch_adr_o  = adr_q;
  assign ch_dat_o  = dat_q;
  assign ch_we_o   = we_q;
  assign err_cnt_o = errCnt_q;

endmodule

// File: doc/gps_wb_chan_arbiter.md
Name: gps_wb_chan_arbiter

Overview:
- Wishbone slave-side controller between the host bus and the NUM_CH gps_single_channel register banks of the multichannel GPS engine.
- Decodes page wb_adr_i[15:8] to a channel and forwards the access as a registered single-target transaction.
- Returns that channel's read data and ack, or terminates with wb_err_o on an unmapped page or a channel timeout.
- Replaces the combinational strobe decode and ack OR with an FSM that has one outstanding transaction, a watchdog and an error counter.

Parameters:
- NUM_CH, 8, number of channel register banks (1..16)
- BASE_PAGE, 8'h0A, page of channel 0; channel n sits at BASE_PAGE+n
- TIMEOUT, 16, cycles to wait for a channel ack before erroring (2..255)
- DW, 32, data width

Ports:
- wb_clk_i  in  1  bus clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wb_adr_i  in  32  host address
- wb_dat_i  in  DW  host write data
- wb_dat_o  out  DW  registered read data
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle valid
- wb_ack_o  out  1  one-cycle normal termination
- wb_err_o  out  1  one-cycle error termination
- ch_cyc_o  out  1  cycle to channels
- ch_stb_o  out  NUM_CH  one-hot strobe to selected channel
- ch_adr_o  out  8  latched wb_adr_i[7:0]
- ch_dat_o  out  DW  latched write data
- ch_we_o  out  1  latched write enable
- ch_dat_i  in  NUM_CH*DW  concatenated channel read data, channel n at [n*DW +: DW]
- ch_ack_i  in  NUM_CH  channel acks
- err_cnt_o  out  8  saturating count of error terminations

Behaviour:
- Reset: all outputs 0, including wb_dat_o and err_cnt_o; FSM goes to IDLE; timer cleared. Reset asserted in any state aborts immediately; no ack or err is issued afterwards.
- FSM states: IDLE, FWD, RESP, ERR.
- IDLE: samples wb_cyc_i & wb_stb_i. Computes idx = wb_adr_i[15:8] - BASE_PAGE.
  - idx < NUM_CH (unsigned, 8-bit compare): latch idx, adr[7:0], dat, we; go to FWD.
  - Otherwise: go to ERR.
- FWD: ch_cyc_o=1, ch_stb_o[idx]=1, other strobe bits 0. Timer increments each cycle.
  - ch_ack_i[idx]=1: capture ch_dat_i slice idx into wb_dat_o on reads only (writes leave wb_dat_o unchanged); go to RESP.
  - Timer reaches TIMEOUT-1 with no ack: go to ERR.
  - wb_cyc_i drops: go to IDLE with no termination; wb_dat_o unchanged.
  - Priority: cyc drop > ack > timeout on the same cycle.
- RESP: wb_ack_o=1 for exactly one cycle; channel outputs deasserted; go to IDLE.
- ERR: wb_err_o=1 for exactly one cycle; err_cnt_o += 1, saturating at 255; go to IDLE.
- ack and err are never asserted together.
- Latency: request sampled at cycle 0; ch_stb_o high from cycle 1. A channel ack at cycle k gives wb_ack_o at k+1. An unmapped page gives wb_err_o at cycle 1.
- IDLE accepts a new request the cycle after RESP or ERR. A master holding stb high starts a new transaction (classic Wishbone).
- ch_ack_i bits of non-selected channels, and any ack outside FWD, are ignored.
- ch_adr_o, ch_dat_o and ch_we_o hold their latched values until the next accept.

Decomposition:
- Shared package gps_wb_pkg holds:
  - state enum (IDLE/FWD/RESP/ERR, 2-bit)
  - BASE_PAGE and NUM_CH defaults
  - PAGE_W=8 and OFS_W=8 constants
  - error counter width
- One sub-module, gps_wb_rdmux: parameterised NUM_CH:1 slice mux of ch_dat_i and ch_ack_i by idx. It is combinational and is reused by the engine top.

Test Plan:
- Read adr 0x0000_0A04; ch0 acks 2 cycles after ch_stb_o[0] rises with data 0xDEADBEEF -> ch_adr_o=0x04, wb_ack_o one cycle later, wb_dat_o=0xDEADBEEF, err_cnt_o=0.
- Write 0x1110, dat 0x12345678; ch7 acks -> ch_stb_o=8'h80, ch_we_o=1, ch_dat_o=0x12345678, wb_ack_o pulses, wb_dat_o keeps its previous value.
- Access 0x0900 and 0x1200 -> no ch_stb_o; wb_err_o at cycle 1 for each; err_cnt_o=2.
- Read 0x0C00 with ch2 silent, TIMEOUT=16 -> ch_stb_o[2] high for 16 cycles, then wb_err_o pulse, err_cnt_o +1. A ch3 ack injected mid-wait is ignored.
- wb_cyc_i dropped at FWD cycle 3 -> ch_stb_o cleared next cycle; no ack or err; a subsequent read to 0x0B00 completes normally.
- wb_rst_i pulsed during FWD -> all outputs 0 asynchronously; a later ch_ack_i is ignored. 300 forced errors -> err_cnt_o saturates at 255.
